keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 233 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: rotates an active-low column drive, debounces the
// lowest-index low row and presents a sticky key code for software polling.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SCAN     | rotating columns on each tick, waiting for any row low
// ST_DEBOUNCE | column held, counting ticks the candidate row stays low
// ST_HELD     | key accepted, column held, counting all-high ticks to release
module keypad_scan #(
   parameter int CDBITS   = 18,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   input  logic       ack,
   output logic [3:0] key,
   output logic       valid,
   output logic       pressed,
   output logic       overrun
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   localparam logic [3:0]        DB_TC   = 4'(DEBOUNCE);
   localparam logic [CDBITS-1:0] DIV_ONE = CDBITS'(1);

   state_t              state_q;
   state_t              state_d;
   logic [3:0]          row_meta;
   logic [3:0]          row_sync;
   logic [CDBITS-1:0]   div_cnt;
   logic                tick;
   logic [3:0]          row_low;
   logic                any_low;
   logic [1:0]          prio_row;
   logic [1:0]          col_idx;
   logic [1:0]          cand_row;
   logic [3:0]          cnt_q;
   logic [3:0]          cnt_d;
   logic [3:0]          cnt_inc;
   logic                cand_match;
   logic                accept;
   logic                rotate;
   logic                load_cand;
   logic                release_key;
   logic [1:0]          acc_row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   assign tick    = &div_cnt;
   assign row_low = ~row_sync;
   assign any_low = |row_low;
   assign cnt_inc = cnt_q + 4'd1;

   // lowest-index low row wins when several rows are pulled down
   always_comb begin
      prio_row = 2'd0;
      if (row_low[0]) begin
         prio_row = 2'd0;
      end else if (row_low[1]) begin
         prio_row = 2'd1;
      end else if (row_low[2]) begin
         prio_row = 2'd2;
      end else if (row_low[3]) begin
         prio_row = 2'd3;
      end
   end

   always_comb begin
      col_idx = 2'd0;
      case (col_out)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   assign cand_match = any_low && (prio_row == cand_row);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SCAN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SCAN: begin
            if (tick && any_low) begin
               state_d = (DEBOUNCE == 1) ? ST_HELD : ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (!cand_match) begin
                  state_d = ST_SCAN;
               end else if (cnt_inc == DB_TC) begin
                  state_d = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (tick && !any_low && (cnt_inc == DB_TC)) begin
               state_d = ST_SCAN;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   // cnt_q counts qualifying press ticks in ST_DEBOUNCE, all-high ticks in ST_HELD
   always_comb begin
      accept      = 1'b0;
      rotate      = 1'b0;
      load_cand   = 1'b0;
      release_key = 1'b0;
      acc_row     = cand_row;
      cnt_d       = cnt_q;
      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (any_low) begin
                  load_cand = 1'b1;
                  acc_row   = prio_row;
                  if (DEBOUNCE == 1) begin
                     accept = 1'b1;
                     cnt_d  = 4'd0;
                  end else begin
                     cnt_d  = 4'd1;
                  end
               end else begin
                  rotate = 1'b1;
                  cnt_d  = 4'd0;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (tick) begin
               if (!cand_match) begin
                  cnt_d = 4'd0;
               end else if (cnt_inc == DB_TC) begin
                  accept = 1'b1;
                  cnt_d  = 4'd0;
               end else begin
                  cnt_d  = cnt_inc;
               end
            end
         end
         ST_HELD: begin
            if (tick) begin
               if (any_low) begin
                  cnt_d = 4'd0;
               end else if (cnt_inc == DB_TC) begin
                  release_key = 1'b1;
                  cnt_d       = 4'd0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: cnt_d = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_out  <= 4'b1110;
         cand_row <= 2'd0;
         cnt_q    <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
         if (rotate) begin
            col_out <= {col_out[2:0], col_out[3]};
         end
         if (load_cand) begin
            cand_row <= prio_row;
         end
      end
   end

   // an accept in the same clock as ack takes priority over the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key     <= 4'h0;
         valid   <= 1'b0;
         pressed <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (accept) begin
            key     <= {acc_row, col_idx};
            valid   <= 1'b1;
            pressed <= 1'b1;
            overrun <= valid & ~ack;
         end else begin
            if (ack) begin
               valid   <= 1'b0;
               overrun <= 1'b0;
            end
            if (release_key) begin
               pressed <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: accepts are scored by a monitor against a
// queue of expected {key, valid, overrun} pushed by the stimulus thread.
module tb_keypad_scan;

   logic       clk;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       ack;
   logic [3:0] key;
   logic       valid;
   logic       pressed;
   logic       overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];
   logic pressed_prev = 1'b0;

   keypad_scan #(.CDBITS(2), .DEBOUNCE(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .row_in  (row_in),
      .col_out (col_out),
      .ack     (ack),
      .key     (key),
      .valid   (valid),
      .pressed (pressed),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic wait_col(input logic [3:0] target);
      logic [3:0] p;
      bit found;
      found = 1'b0;
      p = col_out;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (col_out == target && p != target) begin
            found = 1'b1;
            break;
         end
         p = col_out;
      end
      if (!found) begin
         n_checks++;
         $display("FAIL wait_col actual=%b required=%b", col_out, target);
      end
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   // monitor: every rising pressed marks an Accept
   always @(negedge clk) begin
      if (pressed && !pressed_prev) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_accept actual key=%0h required none", key);
         end else begin
            chk("accept", {26'd0, key, valid, overrun}, exp_q.pop_front());
         end
      end
      pressed_prev <= pressed;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rot_seq [4];
      logic [3:0] prev_col;
      rot_seq[0] = 4'b1101;
      rot_seq[1] = 4'b1011;
      rot_seq[2] = 4'b0111;
      rot_seq[3] = 4'b1110;

      reset  = 1'b0;
      row_in = 4'hF;
      ack    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_col", col_out, 4'b1110);
      chk("rst_key", key, 0);
      chk("rst_valid", valid, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b1;

      // 1: idle rotation, one column step every 4 clocks
      prev_col = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         repeat (3) @(negedge clk);
         chk("rot_hold", col_out, prev_col);
         @(negedge clk);
         chk("rot_step", col_out, rot_seq[i]);
         chk("rot_valid", valid, 0);
         chk("rot_pressed", pressed, 0);
         prev_col = rot_seq[i];
      end

      // 2: clean press of row 1 on column 2 -> key 6
      wait_col(4'b1011);
      exp_q.push_back({4'h6, 1'b1, 1'b0});
      row_in = 4'b1101;
      repeat (4) @(negedge clk);
      chk("db_not_yet", valid, 0);
      repeat (4) @(negedge clk);
      chk("press_key", key, 6);
      chk("press_pressed", pressed, 1);
      chk("press_col", col_out, 4'b1011);
      repeat (32) @(negedge clk);
      chk("held_col", col_out, 4'b1011);
      row_in = 4'hF;
      repeat (8) @(negedge clk);
      chk("release_pressed", pressed, 0);
      chk("release_col", col_out, 4'b1011);
      repeat (4) @(negedge clk);
      chk("resume_col", col_out, 4'b0111);
      pulse_ack();
      chk("ack_valid", valid, 0);
      chk("ack_key", key, 6);

      // 3: three one-tick bounces of row 2 on column 3, then a real press
      for (int b = 0; b < 3; b++) begin
         wait_col(4'b0111);
         row_in = 4'b1011;
         repeat (4) @(negedge clk);
         row_in = 4'hF;
         repeat (4) @(negedge clk);
         chk("bounce_col_hold", col_out, 4'b0111);
         chk("bounce_valid", valid, 0);
         repeat (4) @(negedge clk);
         chk("bounce_resume", col_out, 4'b1110);
      end
      wait_col(4'b0111);
      exp_q.push_back({4'hB, 1'b1, 1'b0});
      row_in = 4'b1011;
      repeat (8) @(negedge clk);
      chk("stable_key", key, 4'hB);
      row_in = 4'hF;
      repeat (8) @(negedge clk);
      chk("stable_release", pressed, 0);
      pulse_ack();

      // 4: overrun, then ack colliding with an Accept
      wait_col(4'b1110);
      exp_q.push_back({4'h0, 1'b1, 1'b0});
      row_in = 4'b1110;
      repeat (8) @(negedge clk);
      row_in = 4'hF;
      repeat (8) @(negedge clk);
      wait_col(4'b1101);
      exp_q.push_back({4'h5, 1'b1, 1'b1});
      row_in = 4'b1101;
      repeat (8) @(negedge clk);
      chk("ovr_key", key, 5);
      chk("ovr_flag", overrun, 1);
      pulse_ack();
      chk("ovr_ack_valid", valid, 0);
      chk("ovr_ack_flag", overrun, 0);
      row_in = 4'hF;
      wait_col(4'b1011);
      exp_q.push_back({4'hE, 1'b1, 1'b0});
      row_in = 4'b0111;
      repeat (8) @(negedge clk);
      chk("pre_collide_valid", valid, 1);
      row_in = 4'hF;
      wait_col(4'b0111);
      exp_q.push_back({4'h3, 1'b1, 1'b0});
      row_in = 4'b1110;
      repeat (7) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("collide_key", key, 3);
      chk("collide_valid", valid, 1);
      chk("collide_overrun", overrun, 0);
      @(negedge clk);
      chk("collide_valid_after", valid, 1);
      row_in = 4'hF;
      pulse_ack();

      // 5: rows 0 and 3 together on column 2, then rollover while held
      wait_col(4'b1011);
      exp_q.push_back({4'h2, 1'b1, 1'b0});
      row_in = 4'b0110;
      repeat (8) @(negedge clk);
      chk("multi_key", key, 2);
      row_in = 4'b1101;
      repeat (24) @(negedge clk);
      chk("rollover_key", key, 2);
      chk("rollover_pressed", pressed, 1);
      chk("rollover_col", col_out, 4'b1011);
      row_in = 4'hF;
      repeat (8) @(negedge clk);
      chk("rollover_release", pressed, 0);
      pulse_ack();

      // 6a: async reset while debouncing
      wait_col(4'b1101);
      row_in = 4'b1110;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_db_col", col_out, 4'b1110);
      chk("arst_db_key", key, 0);
      chk("arst_db_pressed", pressed, 0);
      row_in = 4'hF;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("arst_db_rot", col_out, 4'b1101);
      repeat (8) @(negedge clk);
      chk("arst_db_valid", valid, 0);

      // 6b: async reset while held with valid set
      wait_col(4'b1101);
      exp_q.push_back({4'hD, 1'b1, 1'b0});
      row_in = 4'b0111;
      repeat (12) @(negedge clk);
      chk("pre_arst_pressed", pressed, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_h_col", col_out, 4'b1110);
      chk("arst_h_key", key, 0);
      chk("arst_h_valid", valid, 0);
      chk("arst_h_pressed", pressed, 0);
      chk("arst_h_overrun", overrun, 0);
      row_in = 4'hF;
      @(negedge clk);
      reset = 1'b1;
      repeat (16) @(negedge clk);
      chk("post_arst_valid", valid, 0);
      chk("post_arst_pressed", pressed, 0);

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
